// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
//
// Parallel-to-serial transmitter for the FIR filter's serial sample link.
// LENGTH-bit words arrive over a valid/ready handshake and leave one bit per
// enabled cycle (i_en=1), LSB first. The last (MSB) bit of each frame is flagged
// with o_dout_valid so the far-end deserializer can latch the finished word.
// A one-word holding buffer lets the next frame start on the enabled cycle
// right after the previous MSB, with no gap.
//
// Parameters:
//    LENGTH        bits per frame (>= 2)
//
// Ports:
//    i_clk         clock
//    i_rst         synchronous, active-high reset
//    i_en          bit strobe; one serial bit is emitted per cycle with i_en=1
//    iv_din        parallel word to transmit
//    i_din_valid   iv_din valid
//    o_din_ready   buffer can take a word (combinational)
//    o_dout        serial data, registered
//    o_dout_valid  high together with the last bit of a frame, registered
//    o_busy        a frame is shifting or a word is waiting in the hold buffer
//    ov_frame_cnt  (only with SERIALIZER_STATUS_EN) count of completed frames
//
// Build option:
//    SERIALIZER_STATUS_EN  adds the 16-bit wrapping frame counter ov_frame_cnt.
// -----------------------------------------------------------------------------
module serializer #(
   parameter int LENGTH = 24
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [LENGTH-1:0] iv_din,
   input  logic              i_din_valid,
   output logic              o_din_ready,
   output logic              o_dout,
   output logic              o_dout_valid,
   output logic              o_busy
`ifdef SERIALIZER_STATUS_EN
   ,
   output logic [15:0]       ov_frame_cnt
`endif
);

   localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [LENGTH-1:0] shifter;
   logic [LENGTH-1:0] hold;
   logic              hold_full;
   logic [CNT_W-1:0]  cnt;
   logic              last_bit;
   logic              free;
   logic              accept;
   logic              load;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. The shifter is "free" when idle or when its last bit is
   // going out this cycle; a free shifter loads from the hold buffer first,
   // otherwise straight from the input, and drops to IDLE if nothing is there.
   always_comb begin
      last_bit   = (state == SHIFT) && i_en && (cnt == LAST_CNT);
      free       = (state == IDLE) || last_bit;
      accept     = i_din_valid && o_din_ready;
      load       = free && (hold_full || accept);
      next_state = state;
      if (free) begin
         next_state = load ? SHIFT : IDLE;
      end
   end

   // Output logic. Ready depends only on the hold buffer, so a word can be
   // taken even while the shifter is mid-frame or the link is stalled.
   always_comb begin
      o_din_ready = !hold_full && !i_rst;
      o_busy      = (state == SHIFT) || hold_full;
   end

   // Datapath: serial output, shifter, bit counter and hold buffer.
   // A shifter load on the last-bit cycle overrides the shift so the next
   // frame's bit 0 is ready for the following enabled cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_dout       <= 1'b0;
         o_dout_valid <= 1'b0;
         shifter      <= '0;
         hold         <= '0;
         hold_full    <= 1'b0;
         cnt          <= '0;
      end else begin
         if (i_en) begin
            if (state == SHIFT) begin
               o_dout       <= shifter[0];
               o_dout_valid <= (cnt == LAST_CNT);
               shifter      <= {1'b0, shifter[LENGTH-1:1]};
               cnt          <= cnt + CNT_W'(1);
            end else begin
               o_dout       <= 1'b0;
               o_dout_valid <= 1'b0;
            end
         end

         if (load) begin
            shifter <= hold_full ? hold : iv_din;
            cnt     <= '0;
         end

         if (free && hold_full) begin
            if (accept) begin
               hold <= iv_din;
            end else begin
               hold_full <= 1'b0;
            end
         end else if (!free && accept) begin
            hold      <= iv_din;
            hold_full <= 1'b1;
         end
      end
   end

`ifdef SERIALIZER_STATUS_EN
   // Completed-frame counter; steps exactly when o_dout_valid is being set.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ov_frame_cnt <= 16'd0;
      end else if (last_bit) begin
         ov_frame_cnt <= ov_frame_cnt + 16'd1;
      end
   end
`else
   // No frame counter in this build.
`endif

endmodule

// File: tb/tb_serializer.sv
// -----------------------------------------------------------------------------
// tb_serializer
//
// Self-checking bench for serializer. An 8-bit instance covers the directed
// bit-level scenarios; a 24-bit instance is looped back into a small receiver
// model with a random bit strobe. Words are pushed to a per-instance queue when
// the handshake accepts them and popped when o_dout_valid marks a finished
// frame; the receiver reassembles the serial bits LSB first.
// -----------------------------------------------------------------------------
module tb_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;

   logic       en8 = 1'b1;
   logic [7:0] din8 = '0;
   logic       din_valid8 = 1'b0;
   logic       din_ready8;
   logic       dout8;
   logic       dout_valid8;
   logic       busy8;

   logic        en24 = 1'b1;
   logic [23:0] din24 = '0;
   logic        din_valid24 = 1'b0;
   logic        din_ready24;
   logic        dout24;
   logic        dout_valid24;
   logic        busy24;

`ifdef SERIALIZER_STATUS_EN
   logic [15:0] frame_cnt8;
   logic [15:0] frame_cnt24;
`endif

   int checks = 0;
   int passes = 0;

   logic [7:0]  exp_q8[$];
   logic [23:0] exp_q24[$];
   logic [7:0]  rx8 = '0;
   logic [23:0] rx24 = '0;
   int          frames24 = 0;

   serializer #(.LENGTH(8)) u_dut8 (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en8),
      .iv_din       (din8),
      .i_din_valid  (din_valid8),
      .o_din_ready  (din_ready8),
      .o_dout       (dout8),
      .o_dout_valid (dout_valid8),
      .o_busy       (busy8)
`ifdef SERIALIZER_STATUS_EN
      ,
      .ov_frame_cnt (frame_cnt8)
`endif
   );

   serializer #(.LENGTH(24)) u_dut24 (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en24),
      .iv_din       (din24),
      .i_din_valid  (din_valid24),
      .o_din_ready  (din_ready24),
      .o_dout       (dout24),
      .o_dout_valid (dout_valid24),
      .o_busy       (busy24)
`ifdef SERIALIZER_STATUS_EN
      ,
      .ov_frame_cnt (frame_cnt24)
`endif
   );

   // Scoreboard for the 8-bit instance: push on accept, reassemble bits on
   // enabled edges, pop and compare when the frame-end flag appears.
   always begin : mon8
      logic       en_e;
      logic       rst_e;
      logic       acc_e;
      logic [7:0] din_e;
      logic [7:0] exp_w;
      @(posedge clk);
      en_e  = en8;
      rst_e = rst;
      acc_e = din_valid8 && din_ready8;
      din_e = din8;
      #1;
      if (rst_e) begin
         exp_q8.delete();
         rx8 = '0;
      end else begin
         if (acc_e) exp_q8.push_back(din_e);
         if (en_e) begin
            rx8 = {dout8, rx8[7:1]};
            if (dout_valid8) begin
               checks++;
               if (exp_q8.size() == 0) begin
                  $display("[TB] FAIL mon8_word: got %h but no word was pending", rx8);
               end else begin
                  exp_w = exp_q8.pop_front();
                  if (rx8 !== exp_w)
                     $display("[TB] FAIL mon8_word: got %h expected %h", rx8, exp_w);
                  else
                     passes++;
               end
            end
         end
      end
   end

   // Same scoreboard for the 24-bit loopback instance.
   always begin : mon24
      logic        en_e;
      logic        rst_e;
      logic        acc_e;
      logic [23:0] din_e;
      logic [23:0] exp_w;
      @(posedge clk);
      en_e  = en24;
      rst_e = rst;
      acc_e = din_valid24 && din_ready24;
      din_e = din24;
      #1;
      if (rst_e) begin
         exp_q24.delete();
         rx24 = '0;
      end else begin
         if (acc_e) exp_q24.push_back(din_e);
         if (en_e) begin
            rx24 = {dout24, rx24[23:1]};
            if (dout_valid24) begin
               frames24++;
               checks++;
               if (exp_q24.size() == 0) begin
                  $display("[TB] FAIL mon24_word: got %h but no word was pending", rx24);
               end else begin
                  exp_w = exp_q24.pop_front();
                  if (rx24 !== exp_w)
                     $display("[TB] FAIL mon24_word: got %h expected %h", rx24, exp_w);
                  else
                     passes++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle8(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!busy8) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      repeat (2) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (dout8 !== 1'b0 || dout_valid8 !== 1'b0 || busy8 !== 1'b0 || din_ready8 !== 1'b0)
         $display("[TB] FAIL reset_state: dout=%b valid=%b busy=%b ready=%b expected 0 0 0 0",
                  dout8, dout_valid8, busy8, din_ready8);
      else
         passes++;
      checks++;
      if (dout24 !== 1'b0 || dout_valid24 !== 1'b0 || busy24 !== 1'b0)
         $display("[TB] FAIL reset_state24: dout=%b valid=%b busy=%b expected 0 0 0",
                  dout24, dout_valid24, busy24);
      else
         passes++;
      rst = 1'b0;
      #1;
      checks++;
      if (din_ready8 !== 1'b1)
         $display("[TB] FAIL reset_release_ready: got %b expected 1", din_ready8);
      else
         passes++;
      tick();
   endtask

   task automatic test_single();
      bit exp_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      din8       = 8'hA5;
      din_valid8 = 1'b1;
      tick();
      din_valid8 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (dout8 !== exp_bits[k] || dout_valid8 !== (k == 7))
            $display("[TB] FAIL single_bit%0d: dout=%b valid=%b expected %b %b",
                     k, dout8, dout_valid8, exp_bits[k], (k == 7));
         else
            passes++;
      end
      tick();
      checks++;
      if (dout8 !== 1'b0 || dout_valid8 !== 1'b0 || busy8 !== 1'b0)
         $display("[TB] FAIL single_after: dout=%b valid=%b busy=%b expected 0 0 0",
                  dout8, dout_valid8, busy8);
      else
         passes++;
   endtask

   task automatic test_back_to_back();
      bit exp_bits[16] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
      bit ok;
      din8       = 8'h3C;
      din_valid8 = 1'b1;
      tick();
      din8 = 8'hC3;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (k == 0) begin
            din_valid8 = 1'b0;
            checks++;
            if (din_ready8 !== 1'b0)
               $display("[TB] FAIL b2b_hold_ready: got %b expected 0", din_ready8);
            else
               passes++;
         end
         checks++;
         if (dout8 !== exp_bits[k] || dout_valid8 !== (k == 7 || k == 15))
            $display("[TB] FAIL b2b_bit%0d: dout=%b valid=%b expected %b %b",
                     k, dout8, dout_valid8, exp_bits[k], (k == 7 || k == 15));
         else
            passes++;
      end
      wait_idle8(ok);
      checks++;
      if (!ok || exp_q8.size() != 0)
         $display("[TB] FAIL b2b_drain: idle=%b pending=%0d expected 1 0", ok, exp_q8.size());
      else
         passes++;
   endtask

   task automatic test_backpressure();
      bit ok;
      din8       = 8'h12;
      din_valid8 = 1'b1;
      tick();
      din8 = 8'h34;
      tick();
      din8 = 8'hFF;
      checks++;
      if (din_ready8 !== 1'b0)
         $display("[TB] FAIL bp_ready_full: got %b expected 0", din_ready8);
      else
         passes++;
      for (int k = 2; k <= 8; k++) begin
         tick();
         checks++;
         if (din_ready8 !== (k == 8))
            $display("[TB] FAIL bp_ready_edge%0d: got %b expected %b", k, din_ready8, (k == 8));
         else
            passes++;
      end
      tick();
      din_valid8 = 1'b0;
      wait_idle8(ok);
      checks++;
      if (!ok || exp_q8.size() != 0)
         $display("[TB] FAIL bp_drain: idle=%b pending=%0d expected 1 0", ok, exp_q8.size());
      else
         passes++;
   endtask

   task automatic test_sparse_en();
      logic prev_dout;
      logic prev_valid;
      logic en_edge;
      int   valid_cycles = 0;
      prev_dout  = dout8;
      prev_valid = dout_valid8;
      din8       = 8'h81;
      din_valid8 = 1'b1;
      for (int c = 0; c < 36; c++) begin
         en8     = (c % 3 == 0);
         en_edge = en8;
         tick();
         din_valid8 = 1'b0;
         if (!en_edge) begin
            checks++;
            if (dout8 !== prev_dout || dout_valid8 !== prev_valid)
               $display("[TB] FAIL sparse_hold_c%0d: dout=%b valid=%b expected %b %b",
                        c, dout8, dout_valid8, prev_dout, prev_valid);
            else
               passes++;
         end
         if (dout_valid8) valid_cycles++;
         prev_dout  = dout8;
         prev_valid = dout_valid8;
      end
      en8 = 1'b1;
      checks++;
      if (valid_cycles != 3)
         $display("[TB] FAIL sparse_valid_len: got %0d clocks expected 3", valid_cycles);
      else
         passes++;
      tick();
   endtask

   task automatic test_reset_midframe();
      bit ok;
      din8       = 8'hF0;
      din_valid8 = 1'b1;
      tick();
      din8 = 8'h0F;
      tick();
      din_valid8 = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      checks++;
      if (dout8 !== 1'b0 || dout_valid8 !== 1'b0 || busy8 !== 1'b0 || din_ready8 !== 1'b0)
         $display("[TB] FAIL midreset_state: dout=%b valid=%b busy=%b ready=%b expected 0 0 0 0",
                  dout8, dout_valid8, busy8, din_ready8);
      else
         passes++;
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (dout8 !== 1'b0 || dout_valid8 !== 1'b0)
            $display("[TB] FAIL midreset_quiet%0d: dout=%b valid=%b expected 0 0",
                     k, dout8, dout_valid8);
         else
            passes++;
      end
      din8       = 8'h55;
      din_valid8 = 1'b1;
      tick();
      din_valid8 = 1'b0;
      wait_idle8(ok);
      checks++;
      if (!ok || exp_q8.size() != 0)
         $display("[TB] FAIL midreset_resume: idle=%b pending=%0d expected 1 0", ok, exp_q8.size());
      else
         passes++;
   endtask

   task automatic test_loopback();
      logic [23:0] w;
      bit          acc;
      bit          ok = 1'b1;
      bit          idle = 1'b0;
      for (int i = 0; i < 100 && ok; i++) begin
         if (i == 0)      w = 24'h000000;
         else if (i == 1) w = 24'hFFFFFF;
         else if (i == 2) w = 24'h123456;
         else             w = 24'($urandom);
         din24       = w;
         din_valid24 = 1'b1;
         acc         = 1'b0;
         for (int j = 0; j < 500 && !acc; j++) begin
            acc  = din_ready24;
            en24 = 1'($urandom_range(0, 1));
            tick();
         end
         if (!acc) ok = 1'b0;
      end
      din_valid24 = 1'b0;
      en24        = 1'b1;
      checks++;
      if (!ok)
         $display("[TB] FAIL loop_accept_timeout: accepted=%b expected 1", ok);
      else
         passes++;
      for (int i = 0; i < 2000; i++) begin
         if (!busy24) begin
            idle = 1'b1;
            break;
         end
         tick();
      end
      repeat (2) tick();
      checks++;
      if (!idle || exp_q24.size() != 0 || frames24 != 100)
         $display("[TB] FAIL loop_frames: idle=%b pending=%0d frames=%0d expected 1 0 100",
                  idle, exp_q24.size(), frames24);
      else
         passes++;
`ifdef SERIALIZER_STATUS_EN
      checks++;
      if (frame_cnt24 !== 16'd100)
         $display("[TB] FAIL loop_frame_cnt: got %0d expected 100", frame_cnt24);
      else
         passes++;
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_sparse_en();
      test_reset_midframe();
      test_loopback();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial transmitter for the FIR filter's serial sample link.
- Takes LENGTH-bit words over a valid/ready handshake and emits them one bit per enabled cycle, LSB first.
- Flags the last (MSB) bit of each frame with o_dout_valid, so the deserializer on the far end latches the completed word on that bit.
- Sits between the filter output datapath and the serial link; a one-word holding buffer allows back-to-back frames with no gap.

Parameters:
- LENGTH, 24, bits per frame (>= 2).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_en  in  1  bit strobe / clock enable; one serial bit per cycle with i_en=1
- iv_din  in  LENGTH  parallel word to transmit
- i_din_valid  in  1  iv_din valid
- o_din_ready  out  1  buffer can accept a word; combinational = !hold_full && !i_rst
- o_dout  out  1  serial data, registered
- o_dout_valid  out  1  high with last bit of frame, registered
- o_busy  out  1  state==SHIFT or hold_full

Behaviour:
- Reset is synchronous, active-high, on i_clk. Reset values:
  - o_dout=0, o_dout_valid=0, o_busy=0.
  - Shifter, hold register, hold_full and bit counter cleared; state IDLE.
  - o_din_ready=0 while i_rst=1.
- Reset mid-frame aborts the frame, discards the hold word, and emits no o_dout_valid.
- Handshake:
  - Word accepted on a cycle with i_din_valid && o_din_ready.
  - iv_din is sampled that cycle.
  - Independent of i_en.
- "free" = (state==IDLE) || (state==SHIFT && i_en && cnt==LENGTH-1).
- Load rules, evaluated every cycle:
  - free and hold_full: shifter <= hold; accepted word (if any) -> hold, else hold_full <= 0.
  - free, hold empty, word accepted: shifter <= iv_din directly.
  - free, nothing available: state -> IDLE.
  - not free, word accepted: hold <= iv_din, hold_full <= 1.
  - Any shifter load: cnt <= 0, state SHIFT.
- States:
  - IDLE: no frame in progress.
  - SHIFT: cnt counts 0..LENGTH-1.
  - SHIFT -> IDLE only on the last bit with nothing to load.
  - IDLE -> SHIFT on any load.
- Output update, only on i_en=1 cycles (otherwise o_dout and o_dout_valid hold their values):
  - SHIFT: o_dout <= shifter[0]; shifter >>= 1; cnt++; o_dout_valid <= (cnt==LENGTH-1).
  - IDLE: o_dout <= 0; o_dout_valid <= 0.
- Latency: a word accepted into an idle block at cycle t puts bit0 on o_dout after the first i_en edge after t. Frame completes LENGTH enabled cycles later.
- Back-to-back:
  - Next frame's bit0 follows the previous MSB on the very next i_en cycle.
  - Holds if the next word is in hold, or is accepted on the last-bit cycle.
- Backpressure:
  - Shifter busy and hold full -> o_din_ready=0.
  - i_din_valid with o_din_ready=0 is ignored; the word is not consumed.
- i_en=0 for any duration freezes shifter, cnt and outputs; the handshake still operates.
- Receiver pairing: identical LENGTH, same i_en. The deserializer recovers the word one i_en strobe after o_dout_valid.

Optional Feature:
- Macro SERIALIZER_STATUS_EN.
- Defined:
  - Adds port ov_frame_cnt, out, 16 bits.
  - Reset 0; increments on every i_en cycle where o_dout_valid is set to 1; wraps 0xFFFF -> 0x0000.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- LENGTH=8, i_en=1 constant, send 0xA5:
  - o_dout sequence 1,0,1,0,0,1,0,1.
  - o_dout_valid=1 only on the 8th bit.
  - IDLE after; o_dout=0 afterwards.
- LENGTH=8, send 0x3C then 0xC3 with i_din_valid held:
  - Second accepted into hold; 16 contiguous bits 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1.
  - o_dout_valid pulses on bits 8 and 16; no gap.
- Third word 0xFF offered while shifter and hold both full:
  - o_din_ready=0 and the word is not taken.
  - Ready returns 1 the cycle after the first frame's last bit; 0xFF transmitted third.
- i_en=1 every 3rd cycle, send 0x81:
  - Outputs change only on enable cycles.
  - Frame spans 24 clocks; o_dout_valid held 3 clocks with the last bit.
- Assert i_rst after 4 bits of 0xF0 with 0x0F in hold:
  - Next edge o_dout=0, o_dout_valid=0, o_busy=0.
  - No further bits; a new word 0x55 after reset transmits cleanly.
- Loopback into the deserializer, LENGTH=24, random i_en, 100 random words (including 0x000000, 0xFFFFFF, 0x123456):
  - Each word appears on deserializer ov_dout with o_dout_valid, in order.
  - With SERIALIZER_STATUS_EN, ov_frame_cnt=100.
